// File: rtl/instr_result_reader.sv
// Read-side walker for the instruction register: fetches each entry in a
// pointer range, recomputes its result and streams it out over valid/ready,
// flagging entries whose stored result disagrees with the recomputed one.

package instr_result_pkg;
  typedef logic [4:0]         address_t;
  typedef logic [3:0]         opcode_t;
  typedef logic signed [31:0] operand_t;
  typedef logic [61:0]        rezultat_t;

  typedef struct packed {
    opcode_t   opc;
    operand_t  a;
    operand_t  b;
    rezultat_t rezultat;
  } instruction_t;

  localparam opcode_t OP_ZERO  = 4'd0;
  localparam opcode_t OP_PASSA = 4'd1;
  localparam opcode_t OP_PASSB = 4'd2;
  localparam opcode_t OP_ADD   = 4'd3;
  localparam opcode_t OP_SUB   = 4'd4;
  localparam opcode_t OP_MULT  = 4'd5;
  localparam opcode_t OP_DIV   = 4'd6;
  localparam opcode_t OP_MOD   = 4'd7;
  localparam opcode_t OP_POW   = 4'd8;
endpackage

module instr_result_reader
  import instr_result_pkg::*;
#(
  parameter bit CHECK_EN   = 1'b1,
  parameter int FETCH_WAIT = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  address_t     first_ptr,
  input  address_t     last_ptr,
  output address_t     read_pointer,
  input  instruction_t instruction_word,
  output logic         busy,
  output logic         res_valid,
  input  logic         res_ready,
  output address_t     res_addr,
  output opcode_t      res_opc,
  output rezultat_t    res_value,
  output logic         res_mismatch,
  output logic [15:0]  err_count,
  output logic         done
);
  localparam int WW = $clog2(FETCH_WAIT) + 1;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_OUT, S_DONE} state_t;

  state_t       state_q, state_d;
  address_t     rp_q, rp_d, last_q, last_d;
  logic         busy_q, busy_d, mis_q, mis_d;
  logic [15:0]  err_q, err_d;
  logic [WW-1:0] wait_q, wait_d;
  instruction_t word_q, word_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [63:0]  acc_q, acc_d, base_q, base_d;
  rezultat_t    val_q, val_d;

  logic signed [63:0] a64, b64, alu;
  logic [63:0]  acc_step, base_sq, pow_res;

  assign a64 = {{32{word_q.a[31]}}, word_q.a};
  assign b64 = {{32{word_q.b[31]}}, word_q.b};

  // Single-cycle datapath for every opcode except POW.
  always_comb begin
    alu = '0;
    case (word_q.opc)
      OP_PASSA: alu = a64;
      OP_PASSB: alu = b64;
      OP_ADD:   alu = a64 + b64;
      OP_SUB:   alu = a64 - b64;
      OP_MULT:  alu = a64 * b64;
      OP_DIV:   alu = (b64 == 0) ? 64'sd0 : a64 / b64;
      OP_MOD:   alu = (b64 == 0) ? 64'sd0 : a64 % b64;
      default:  alu = '0;
    endcase
  end

  // One square-and-multiply step, exponent bit cnt_q (LSB first); negative
  // exponents collapse to 0 once all 32 bits have been consumed.
  always_comb begin
    acc_step = word_q.b[cnt_q] ? acc_q * base_q : acc_q;
    base_sq  = base_q * base_q;
    pow_res  = word_q.b[31] ? 64'd0 : acc_step;
  end

  function automatic logic mis_of(input opcode_t opc, input rezultat_t v, input rezultat_t st);
    return CHECK_EN && ((opc > OP_POW) || (v != st));
  endfunction

  // Next-state logic for the walk FSM and its datapath registers.
  always_comb begin
    state_d = state_q;
    rp_d    = rp_q;
    last_d  = last_q;
    busy_d  = busy_q;
    err_d   = err_q;
    wait_d  = wait_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    base_d  = base_q;
    val_d   = val_q;
    mis_d   = mis_q;
    case (state_q)
      S_IDLE: if (start) begin
        rp_d    = first_ptr;
        last_d  = last_ptr;
        err_d   = '0;
        busy_d  = 1'b1;
        wait_d  = '0;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (wait_q == WW'(FETCH_WAIT - 1)) begin
          word_d  = instruction_word;
          cnt_d   = '0;
          acc_d   = 64'd1;
          base_d  = {{32{instruction_word.a[31]}}, instruction_word.a};
          state_d = S_EXEC;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_EXEC: begin
        if (word_q.opc == OP_POW) begin
          acc_d  = acc_step;
          base_d = base_sq;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == 5'd31) begin
            val_d   = pow_res[61:0];
            mis_d   = mis_of(word_q.opc, pow_res[61:0], word_q.rezultat);
            state_d = S_OUT;
          end
        end else begin
          val_d   = alu[61:0];
          mis_d   = mis_of(word_q.opc, alu[61:0], word_q.rezultat);
          state_d = S_OUT;
        end
      end
      S_OUT: if (res_ready) begin
        if (mis_q && err_q != 16'hFFFF) err_d = err_q + 16'd1;
        if (rp_q == last_q) begin
          state_d = S_DONE;
        end else begin
          rp_d    = rp_q + 5'd1;
          wait_d  = '0;
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset clears every output-facing flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      rp_q    <= '0;
      last_q  <= '0;
      busy_q  <= 1'b0;
      err_q   <= '0;
      wait_q  <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      base_q  <= '0;
      val_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rp_q    <= rp_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      base_q  <= base_d;
      val_q   <= val_d;
      mis_q   <= mis_d;
    end
  end

  assign read_pointer = rp_q;
  assign res_addr     = rp_q;
  assign res_opc      = word_q.opc;
  assign res_value    = val_q;
  assign res_mismatch = mis_q;
  assign res_valid    = (state_q == S_OUT);
  assign done         = (state_q == S_DONE);
  assign busy         = busy_q;
  assign err_count    = err_q;
endmodule

// File: tb/tb_instr_result_reader.sv
// Directed bench: table of single-entry walks plus hand sequences for
// multi-entry walks, wrap-around, backpressure and reset mid-POW.
module tb_instr_result_reader;
  import instr_result_pkg::*;

  logic clk = 0, reset_n = 0, start = 0, res_ready = 1;
  address_t first_ptr = '0, last_ptr = '0;
  instruction_t mem [32];
  instruction_t iw, iw_c;

  address_t read_pointer, res_addr, read_pointer_c, res_addr_c;
  opcode_t res_opc, res_opc_c;
  rezultat_t res_value, res_value_c;
  logic busy, res_valid, res_mismatch, done;
  logic busy_c, res_valid_c, res_mismatch_c, done_c;
  logic [15:0] err_count, err_count_c;

  assign iw   = mem[read_pointer];
  assign iw_c = mem[read_pointer_c];

  instr_result_reader #(.CHECK_EN(1'b1), .FETCH_WAIT(1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .first_ptr(first_ptr), .last_ptr(last_ptr),
    .read_pointer(read_pointer), .instruction_word(iw), .busy(busy), .res_valid(res_valid),
    .res_ready(res_ready), .res_addr(res_addr), .res_opc(res_opc), .res_value(res_value),
    .res_mismatch(res_mismatch), .err_count(err_count), .done(done));

  instr_result_reader #(.CHECK_EN(1'b0), .FETCH_WAIT(1)) dut_nc (
    .clk(clk), .reset_n(reset_n), .start(start), .first_ptr(first_ptr), .last_ptr(last_ptr),
    .read_pointer(read_pointer_c), .instruction_word(iw_c), .busy(busy_c), .res_valid(res_valid_c),
    .res_ready(res_ready), .res_addr(res_addr_c), .res_opc(res_opc_c), .res_value(res_value_c),
    .res_mismatch(res_mismatch_c), .err_count(err_count_c), .done(done_c));

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    address_t addr; opcode_t opc; int a; int b;
    longint st; longint ev; bit mis; int extra;
  } vec_t;
  vec_t tbl [15];

  address_t  q_addr [$];
  rezultat_t q_val  [$];
  opcode_t   q_opc  [$];
  bit        q_mis  [$];
  bit        q_mis_c[$];
  int        first_valid, ndone;
  logic [15:0] end_err, end_err_c;

  function automatic instruction_t mk(input opcode_t o, input int a, input int b, input longint st);
    instruction_t w;
    w.opc = o; w.a = a; w.b = b; w.rezultat = st[61:0];
    return w;
  endfunction

  function automatic logic [63:0] r62(input longint v);
    return {2'b00, v[61:0]};
  endfunction

  // Collect beats until done, bounded.
  task automatic collect(input int max_cyc);
    for (int c = 0; c < max_cyc; c++) begin
      if (res_valid && first_valid < 0) first_valid = c;
      if (res_valid && res_ready) begin
        q_addr.push_back(res_addr); q_val.push_back(res_value); q_opc.push_back(res_opc);
        q_mis.push_back(res_mismatch); q_mis_c.push_back(res_mismatch_c);
      end
      if (done) begin
        ndone++; end_err = err_count; end_err_c = err_count_c;
        break;
      end
      @(negedge clk);
    end
    chk("walk_done_seen", 64'(ndone), 64'd1);
    @(negedge clk);
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    chk("busy_after_done", {63'd0, busy}, 64'd0);
  endtask

  task automatic clear_q();
    q_addr.delete(); q_val.delete(); q_opc.delete(); q_mis.delete(); q_mis_c.delete();
    first_valid = -1; ndone = 0; end_err = 16'hDEAD; end_err_c = 16'hDEAD;
  endtask

  task automatic walk(input address_t f, input address_t l);
    clear_q();
    @(negedge clk); first_ptr = f; last_ptr = l; start = 1;
    @(negedge clk); start = 0;
    collect(400);
  endtask

  initial begin
    int base_lat;
    bit flag;
    rezultat_t hv;
    address_t ha, hrp;

    for (int i = 0; i < 32; i++) mem[i] = '0;
    tbl[0]  = '{5'd0,  OP_ADD,   5, -7, -2,   -2,   1'b0, 0};
    tbl[1]  = '{5'd1,  OP_MULT, -3,  4, -12,  -12,  1'b0, 0};
    tbl[2]  = '{5'd2,  OP_DIV,   9,  0, 0,    0,    1'b0, 0};
    tbl[3]  = '{5'd3,  OP_ZERO,  7,  7, 0,    0,    1'b0, 0};
    tbl[4]  = '{5'd4,  OP_SUB,  10,  3, 8,    7,    1'b1, 0};
    tbl[5]  = '{5'd5,  OP_DIV,  -7,  2, -3,   -3,   1'b0, 0};
    tbl[6]  = '{5'd6,  OP_MOD,  -7,  2, -1,   -1,   1'b0, 0};
    tbl[7]  = '{5'd7,  OP_PASSA, 123, 9, 123, 123,  1'b0, 0};
    tbl[8]  = '{5'd8,  OP_PASSB, 1, -5, -5,   -5,   1'b0, 0};
    tbl[9]  = '{5'd10, OP_POW,   2, 10, 1024, 1024, 1'b0, 31};
    tbl[10] = '{5'd11, OP_POW,  -2,  3, -8,   -8,   1'b0, 31};
    tbl[11] = '{5'd12, OP_POW,   7, -1, 0,    0,    1'b0, 31};
    tbl[12] = '{5'd13, OP_POW,   3,  0, 1,    1,    1'b0, 31};
    tbl[13] = '{5'd14, 4'd12,    4,  4, 0,    0,    1'b1, 0};
    tbl[14] = '{5'd15, OP_MOD,   7,  0, 0,    0,    1'b0, 0};
    for (int i = 0; i < 15; i++) mem[tbl[i].addr] = mk(tbl[i].opc, tbl[i].a, tbl[i].b, tbl[i].st);
    mem[9]  = mk(OP_POW, 3, 20, 0);
    mem[30] = mk(OP_ADD, 1, 1, 2);
    mem[31] = mk(OP_SUB, 0, 1, -1);

    // Reset values.
    #2;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_valid", {63'd0, res_valid}, 64'd0);
    chk("rst_rp", 64'(read_pointer), 64'd0);
    chk("rst_err", 64'(err_count), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1;

    // Reset in the middle of a POW exec.
    @(negedge clk); first_ptr = 5'd9; last_ptr = 5'd9; start = 1;
    @(negedge clk); start = 0;
    repeat (10) @(negedge clk);
    chk("midpow_busy", {63'd0, busy}, 64'd1);
    chk("midpow_rp", 64'(read_pointer), 64'd9);
    #2 reset_n = 0;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_rp", 64'(read_pointer), 64'd0);
    chk("arst_addr", 64'(res_addr), 64'd0);
    chk("arst_valid_done", {62'd0, res_valid, done}, 64'd0);
    chk("arst_val_err", {res_value[47:0], err_count}, 64'd0);
    @(negedge clk); reset_n = 1;
    flag = 0;
    repeat (40) begin @(negedge clk); if (busy || res_valid || done) flag = 1; end
    chk("arst_stays_idle", {63'd0, flag}, 64'd0);

    // Table: one walk per entry.
    base_lat = 0;
    for (int i = 0; i < 15; i++) begin
      walk(tbl[i].addr, tbl[i].addr);
      chk($sformatf("t%0d_beats", i), 64'(q_val.size()), 64'd1);
      if (q_val.size() == 1) begin
        chk($sformatf("t%0d_val", i), {2'b00, q_val[0]}, r62(tbl[i].ev));
        chk($sformatf("t%0d_mis", i), {63'd0, q_mis[0]}, {63'd0, tbl[i].mis});
        chk($sformatf("t%0d_addr", i), 64'(q_addr[0]), 64'(tbl[i].addr));
        chk($sformatf("t%0d_opc", i), 64'(q_opc[0]), 64'(tbl[i].opc));
        chk($sformatf("t%0d_mis_nc", i), {63'd0, q_mis_c[0]}, 64'd0);
      end
      chk($sformatf("t%0d_err", i), 64'(end_err), {63'd0, tbl[i].mis});
      chk($sformatf("t%0d_err_nc", i), 64'(end_err_c), 64'd0);
      if (i == 0) base_lat = first_valid;
      else chk($sformatf("t%0d_lat", i), 64'(first_valid - base_lat), 64'(tbl[i].extra));
    end

    // Three-entry walk.
    walk(5'd0, 5'd2);
    chk("w3_beats", 64'(q_val.size()), 64'd3);
    if (q_val.size() == 3) begin
      chk("w3_a0", 64'(q_addr[0]), 64'd0);
      chk("w3_a2", 64'(q_addr[2]), 64'd2);
      chk("w3_v0", {2'b00, q_val[0]}, r62(-2));
      chk("w3_v1", {2'b00, q_val[1]}, r62(-12));
      chk("w3_v2", {2'b00, q_val[2]}, r62(0));
    end
    chk("w3_err", 64'(end_err), 64'd0);

    // Mixed walk with one bad entry.
    walk(5'd3, 5'd5);
    chk("w345_err", 64'(end_err), 64'd1);
    chk("w345_err_nc", 64'(end_err_c), 64'd0);

    // Wrap through 31 -> 0.
    walk(5'd30, 5'd1);
    chk("wrap_beats", 64'(q_addr.size()), 64'd4);
    if (q_addr.size() == 4)
      chk("wrap_addrs", {44'd0, q_addr[0], q_addr[1], q_addr[2], q_addr[3]},
          {44'd0, 5'd30, 5'd31, 5'd0, 5'd1});

    // Backpressure, with a start pulse while busy.
    clear_q();
    @(negedge clk); first_ptr = 5'd0; last_ptr = 5'd1; start = 1; res_ready = 0;
    @(negedge clk); start = 0;
    flag = 0;
    for (int c = 0; c < 50 && !res_valid; c++) @(negedge clk);
    chk("bp_valid_seen", {63'd0, res_valid}, 64'd1);
    hv = res_value; ha = res_addr; hrp = read_pointer;
    first_ptr = 5'd20; last_ptr = 5'd20; start = 1;
    @(negedge clk); start = 0;
    if (!res_valid || res_value != hv || res_addr != ha || read_pointer != hrp) flag = 1;
    repeat (4) begin
      @(negedge clk);
      if (!res_valid || res_value != hv || res_addr != ha || read_pointer != hrp) flag = 1;
    end
    chk("bp_unstable", {63'd0, flag}, 64'd0);
    chk("bp_val", {2'b00, hv}, r62(-2));
    res_ready = 1;
    collect(200);
    chk("bp_beats", 64'(q_addr.size()), 64'd2);
    if (q_addr.size() == 2) begin
      chk("bp_a1", 64'(q_addr[1]), 64'd1);
      chk("bp_v1", {2'b00, q_val[1]}, r62(-12));
    end
    flag = 0;
    repeat (5) begin @(negedge clk); if (busy) flag = 1; end
    chk("bp_start_ignored", {63'd0, flag}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
